// File: rtl/mul_accum_if.sv
// Handshake bundle between the multiplier-side producer and the
// frame accumulator: product stream in, frame result out.
interface mul_accum_if #(
  parameter int P_WIDTH   = 36,
  parameter int ACC_WIDTH = 40
);
  logic                        in_valid;
  logic                        in_last;
  logic signed [P_WIDTH-1:0]   p;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_ovf;
  logic                        overrun;

  modport master (
    output in_valid,
    output in_last,
    output p,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_ovf,
    input  overrun
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  p,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_ovf,
    output overrun
  );
endinterface

// File: rtl/mul_accum.sv
// Saturating frame accumulator behind a pipelined multiplier.
// Valid/last ride a delay line so they line up with the product.
module mul_accum #(
  parameter int LATENCY   = 3,
  parameter int P_WIDTH   = 36,
  parameter int ACC_WIDTH = 40
) (
  input  logic       clk,
  input  logic       reset,
  mul_accum_if.slave bus
);

  localparam int W = ACC_WIDTH + 1;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] last_q;
  logic [LATENCY:0]   vld_cat;
  logic [LATENCY:0]   last_cat;
  logic               p_valid;
  logic               p_last;

  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic                 first;

  logic [ACC_WIDTH-1:0] base;
  logic [W-1:0]         sum;
  logic                 sat_hi;
  logic                 sat_lo;
  logic                 sat;
  logic [ACC_WIDTH-1:0] clamped;
  logic                 load;

  logic [ACC_WIDTH-1:0] res;
  logic                 res_ovf;
  logic                 res_vld;
  logic                 ovr;

  assign vld_cat  = {vld_q, bus.in_valid};
  assign last_cat = {last_q, bus.in_valid & bus.in_last};
  assign p_valid  = vld_q[LATENCY-1];
  assign p_last   = last_q[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_cat[LATENCY-1:0];
      last_q <= last_cat[LATENCY-1:0];
    end
  end

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    base = first ? '0 : acc;
    sum  = {base[ACC_WIDTH-1], base}
         + {{(W-P_WIDTH){bus.p[P_WIDTH-1]}}, bus.p};
    sat_hi = ~sum[W-1] &  sum[W-2];
    sat_lo =  sum[W-1] & ~sum[W-2];
    sat    = sat_hi | sat_lo;
    unique case (1'b1)
      sat_hi:  clamped = ACC_MAX;
      sat_lo:  clamped = ACC_MIN;
      default: clamped = sum[ACC_WIDTH-1:0];
    endcase
  end

  assign load = p_valid & p_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      ovf   <= 1'b0;
      first <= 1'b1;
    end else if (p_valid) begin
      if (p_last) begin
        acc   <= '0;
        ovf   <= 1'b0;
        first <= 1'b1;
      end else begin
        acc   <= clamped;
        ovf   <= ovf | sat;
        first <= 1'b0;
      end
    end
  end

  // A load while the old result is still unaccepted is an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      res     <= '0;
      res_ovf <= 1'b0;
      res_vld <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (load) begin
        res     <= clamped;
        res_ovf <= ovf | sat;
      end
      res_vld <= load | (res_vld & ~bus.out_ready);
      if (load & res_vld & ~bus.out_ready)
        ovr <= 1'b1;
    end
  end

  assign bus.out_data  = res;
  assign bus.out_ovf   = res_ovf;
  assign bus.out_valid = res_vld;
  assign bus.overrun   = ovr;

endmodule

// File: tb/tb_mul_accum.sv
// Directed bench: models the 18x18 multiplier pipeline in front of
// mul_accum and checks frame sums, saturation, handshake and reset.
module tb_mul_accum;
  localparam int LAT = 3;
  localparam int PW  = 36;
  localparam int AW  = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_accum_if #(.P_WIDTH(PW), .ACC_WIDTH(AW)) bus ();

  logic signed [17:0]   a;
  logic signed [17:0]   b;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] pipe [LAT];

  assign prod = $signed({{18{a[17]}}, a}) * $signed({{18{b[17]}}, b});

  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.p = pipe[LAT-1];

  mul_accum #(
    .LATENCY(LAT),
    .P_WIDTH(PW),
    .ACC_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [AW-1:0] rq [$];
  logic                 oq [$];
  int                   cq [$];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      rq.push_back(bus.out_data);
      oq.push_back(bus.out_ovf);
      cq.push_back(cyc);
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic clearq();
    rq.delete();
    oq.delete();
    cq.delete();
  endtask

  task automatic drive(input logic signed [17:0] x,
                       input logic signed [17:0] y,
                       input logic last);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom);
      a = 18'($urandom);
      b = 18'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_valid got %b want 0", bus.out_valid);
      fails++;
    end
    checks++;
    if (bus.out_data !== '0) begin
      $display("FAIL reset_data got %0d want 0", bus.out_data);
      fails++;
    end
    checks++;
    if (bus.out_ovf !== 1'b0) begin
      $display("FAIL reset_ovf got %b want 0", bus.out_ovf);
      fails++;
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL reset_overrun got %b want 0", bus.overrun);
      fails++;
    end
  endtask

  task automatic test_frame();
    int tl;
    clearq();
    bus.out_ready = 1'b1;
    drive(-19, 253, 1'b0);
    drive(-22, -33, 1'b0);
    drive(-35, 46, 1'b0);
    tl = cyc;
    drive(8, 9, 1'b1);
    idle(8);
    checks++;
    if (rq.size() != 1) begin
      $display("FAIL frame_count got %0d want 1", rq.size());
      fails++;
    end
    if (rq.size() >= 1) begin
      checks++;
      if (rq[0] !== -40'sd5619) begin
        $display("FAIL frame_data got %0d want -5619", rq[0]);
        fails++;
      end
      checks++;
      if (oq[0] !== 1'b0) begin
        $display("FAIL frame_ovf got %b want 0", oq[0]);
        fails++;
      end
      checks++;
      if (cq[0] != tl + 4) begin
        $display("FAIL frame_latency got %0d want %0d", cq[0], tl + 4);
        fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    clearq();
    bus.out_ready = 1'b1;
    t1 = cyc;
    drive(8, 9, 1'b1);
    drive(-19, 253, 1'b0);
    drive(-22, -33, 1'b0);
    drive(-35, 46, 1'b0);
    drive(8, 9, 1'b1);
    idle(8);
    checks++;
    if (rq.size() != 2) begin
      $display("FAIL b2b_count got %0d want 2", rq.size());
      fails++;
    end
    if (rq.size() >= 2) begin
      checks++;
      if (rq[0] !== 40'sd72) begin
        $display("FAIL b2b_single got %0d want 72", rq[0]);
        fails++;
      end
      checks++;
      if (rq[1] !== -40'sd5619) begin
        $display("FAIL b2b_frame got %0d want -5619", rq[1]);
        fails++;
      end
      checks++;
      if (cq[0] != t1 + 4 || cq[1] != t1 + 8) begin
        $display("FAIL b2b_timing got %0d,%0d want %0d,%0d",
                 cq[0], cq[1], t1 + 4, t1 + 8);
        fails++;
      end
    end
  endtask

  task automatic test_saturate();
    logic signed [AW-1:0] exp_d [4];
    logic                 exp_o [4];
    exp_d[0] = 40'sh7F_FFFF_FFFF; exp_o[0] = 1'b1;
    exp_d[1] = 40'sh7C_0000_0000; exp_o[1] = 1'b0;
    exp_d[2] = 40'sh7F_FFFF_FFFE; exp_o[2] = 1'b1;
    exp_d[3] = 40'sh80_0000_0000; exp_o[3] = 1'b1;
    clearq();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++)
      drive(-131072, -131072, 1'(i == 31));
    for (int i = 0; i < 31; i++)
      drive(-131072, -131072, 1'(i == 30));
    for (int i = 0; i < 32; i++)
      drive(-131072, -131072, 1'b0);
    drive(-1, 1, 1'b1);
    for (int i = 0; i < 33; i++)
      drive(-131072, 131071, 1'(i == 32));
    idle(8);
    checks++;
    if (rq.size() != 4) begin
      $display("FAIL sat_count got %0d want 4", rq.size());
      fails++;
    end
    for (int i = 0; i < 4; i++) begin
      if (i < rq.size()) begin
        checks++;
        if (rq[i] !== exp_d[i] || oq[i] !== exp_o[i]) begin
          $display("FAIL sat_frame%0d got %0d/%b want %0d/%b",
                   i, rq[i], oq[i], exp_d[i], exp_o[i]);
          fails++;
        end
      end
    end
  endtask

  task automatic test_single_stream();
    int t;
    do_reset();
    clearq();
    bus.out_ready = 1'b1;
    t = cyc;
    drive(1, 5, 1'b1);
    drive(-2, 7, 1'b1);
    drive(3, 3, 1'b1);
    idle(8);
    checks++;
    if (rq.size() != 3) begin
      $display("FAIL stream_count got %0d want 3", rq.size());
      fails++;
    end
    if (rq.size() >= 3) begin
      checks++;
      if (rq[0] !== 40'sd5 || rq[1] !== -40'sd14 || rq[2] !== 40'sd9) begin
        $display("FAIL stream_data got %0d,%0d,%0d want 5,-14,9",
                 rq[0], rq[1], rq[2]);
        fails++;
      end
      checks++;
      if (cq[0] != t + 4 || cq[1] != t + 5 || cq[2] != t + 6) begin
        $display("FAIL stream_timing got %0d,%0d,%0d want %0d..%0d",
                 cq[0], cq[1], cq[2], t + 4, t + 6);
        fails++;
      end
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL stream_overrun got %b want 0", bus.overrun);
      fails++;
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.out_ready = 1'b0;
    drive(8, 9, 1'b1);
    idle(6);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 40'sd72) begin
      $display("FAIL hold_first got %b/%0d want 1/72",
               bus.out_valid, bus.out_data);
      fails++;
    end
    idle(3);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 40'sd72 ||
        bus.overrun !== 1'b0) begin
      $display("FAIL hold_stable got %b/%0d/%b want 1/72/0",
               bus.out_valid, bus.out_data, bus.overrun);
      fails++;
    end
    drive(2, 3, 1'b1);
    idle(6);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 40'sd6) begin
      $display("FAIL overwrite got %b/%0d want 1/6",
               bus.out_valid, bus.out_data);
      fails++;
    end
    checks++;
    if (bus.overrun !== 1'b1) begin
      $display("FAIL overrun_set got %b want 1", bus.overrun);
      fails++;
    end
    bus.out_ready = 1'b1;
    idle(1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      $display("FAIL accept got valid %b overrun %b want 0/1",
               bus.out_valid, bus.overrun);
      fails++;
    end
    do_reset();
    checks++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL overrun_clear got %b want 0", bus.overrun);
      fails++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    clearq();
    bus.out_ready = 1'b1;
    drive(100, 100, 1'b0);
    drive(-50, 7, 1'b0);
    reset = 1'b1;
    drive(9, 9, 1'b0);
    reset = 1'b0;
    idle(6);
    checks++;
    if (rq.size() != 0) begin
      $display("FAIL midreset_leak got %0d results want 0", rq.size());
      fails++;
    end
    drive(3, 4, 1'b0);
    drive(5, 6, 1'b1);
    idle(8);
    checks++;
    if (rq.size() != 1) begin
      $display("FAIL midreset_count got %0d want 1", rq.size());
      fails++;
    end
    if (rq.size() >= 1) begin
      checks++;
      if (rq[0] !== 40'sd42 || oq[0] !== 1'b0) begin
        $display("FAIL midreset_data got %0d/%b want 42/0",
                 rq[0], oq[0]);
        fails++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    a = '0;
    b = '0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_saturate();
    test_single_stream();
    test_overrun();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 Parameter LATENCY, default 3, SHALL be the upstream multiplier pipeline depth in clk cycles (legal range 1-4).
REQ-003 Parameter P_WIDTH, default 36, SHALL be the signed product width.
REQ-004 Parameter ACC_WIDTH, default 40, SHALL be the signed accumulator and result width (ACC_WIDTH > P_WIDTH).
REQ-005 The ports SHALL be:
- clk  in  1  rising-edge clock, shared with the multiplier.
- reset  in  1  synchronous active-high reset, shared with the multiplier's RST.
- in_valid  in  1  multiplier operands A/B valid this cycle.
- in_last  in  1  marks the final operand pair of a frame; qualified by in_valid.
- p  in  P_WIDTH  signed product from the multiplier, LATENCY cycles after its operands.
- out_data  out  ACC_WIDTH  signed frame sum.
- out_valid  out  1  out_data/out_ovf hold a result.
- out_ready  in  1  downstream accepts the result.
- out_ovf  out  1  saturation occurred in the frame now on out_data.
- overrun  out  1  sticky: an unaccepted result was overwritten.

Function
REQ-006 The block SHALL delay in_valid and in_valid&in_last through a LATENCY-stage shift register to form p_valid and p_last, aligned with p.
REQ-007 While p_valid=0, p SHALL be ignored and the accumulator SHALL hold.
REQ-008 A first flag SHALL be set after reset and after every accepted p_last; while it is set, the accumulation base is 0, otherwise the running accumulator.
REQ-009 On p_valid=1, acc_next SHALL be base + sign-extended p, computed at ACC_WIDTH+1 bits.
REQ-010 If acc_next exceeds 2^(ACC_WIDTH-1)-1, it SHALL clamp to that value; if it is below -2^(ACC_WIDTH-1), it SHALL clamp to that value. In either case a per-frame sticky ovf bit SHALL set.
REQ-011 Once saturated, later terms SHALL continue accumulating from the clamped value; there is no wrap-around.
REQ-012 On p_valid=1 with p_last=1:
- the result register SHALL load acc_next and the frame ovf;
- out_valid SHALL be 1 the next cycle;
- the accumulator, ovf and first SHALL reinitialise for the next frame with no dead cycle.
REQ-013 End-to-end latency SHALL be LATENCY+1 cycles: a last pair presented in cycle t gives out_valid=1 in cycle t+LATENCY+1.
REQ-014 A one-term frame (in_last on the first in_valid) SHALL output exactly p sign-extended.
REQ-015 out_valid SHALL stay high, with out_data and out_ovf stable, until a cycle with out_ready=1; that cycle completes the transfer and out_valid clears unless a new result loads in the same cycle.
REQ-016 If a new result loads while out_valid=1 and out_ready=0, it SHALL overwrite the register, out_valid SHALL stay 1, and overrun SHALL set and hold until reset.
REQ-017 If a new result loads in the same cycle as a completing transfer, out_valid SHALL stay 1 with the new data and overrun SHALL NOT set.
REQ-018 Back-to-back frames with in_valid held continuously SHALL be accepted at one term per cycle.

Reset
REQ-019 Reset SHALL force these values on the next clk edge: out_valid=0, out_data=0, out_ovf=0, overrun=0, accumulator=0, ovf=0, first=1, and every delay-line stage=0.
REQ-020 Reset mid-frame SHALL discard the partial sum and all in-flight valids; no result from pre-reset operands SHALL ever appear.
REQ-021 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-022 Frame of operand pairs (-19,253), (-22,-33), (-35,46), (8,9) on consecutive cycles, last on the 4th, out_ready=1 -> out_data=-5619, out_ovf=0, out_valid for 1 cycle, 4 cycles after the last pair.
REQ-023 Single pair (8,9) with in_last -> out_data=72; then the 4-pair frame of REQ-022 immediately after -> out_data=-5619 with no gap.
REQ-024 32 pairs of (-131072,-131072) in one frame -> out_data=2^39-1, out_ovf=1; a 31-pair frame -> out_data=31*2^34, out_ovf=0.
REQ-025 out_ready=0 across two completed frames -> out_valid stays 1, out_data shows the second sum, overrun=1; a subsequent reset -> overrun=0.
REQ-026 Reset asserted on the cycle after the 2nd pair of a 4-pair frame -> no out_valid; the next full frame produces only its own sum.
